// File: rtl/reaction_pkg.sv
// Shared types and constants for the reaction-tester trial controller.
package reaction_pkg;

   localparam int MS_W = 15;

   localparam logic [15:0] LFSR_SEED = 16'hACE1;
   // Fibonacci taps 16,14,13,11 expressed as a bit mask over state[15:0]
   localparam logic [15:0] LFSR_TAPS = 16'hB400;

   typedef enum logic [2:0] {
      IDLE        = 3'd0,
      WAIT_RAND   = 3'd1,
      GO          = 3'd2,
      DONE        = 3'd3,
      FALSE_START = 3'd4
   } state_t;

endpackage

// File: rtl/reaction_lfsr16.sv
// Free-running 16-bit Fibonacci LFSR; exposes only the low OUT_W bits.
module lfsr16
   import reaction_pkg::*;
#(
   parameter logic [15:0] SEED  = LFSR_SEED,
   parameter logic [15:0] TAPS  = LFSR_TAPS,
   parameter int          OUT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   output logic [OUT_W-1:0] rnd
);

   logic [15:0] state;

   // A non-zero seed with maximal-length taps never reaches the all-zero lockup
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= SEED;
      else     state <= {state[14:0], ^(state & TAPS)};
   end

   assign rnd = state[OUT_W-1:0];

endmodule

// File: rtl/reaction_ctrl.sv
// Trial sequencer for the reaction tester: arm, random fore-period, GO, response, result.
// Optional best-score tracking is enabled with `define REACTION_BEST_SCORE_EN.
module reaction_ctrl
   import reaction_pkg::*;
#(
   parameter int CLKS_PER_MS  = 126000,
   parameter int MIN_DELAY_MS = 1000,
   parameter int RAND_BITS    = 12,
   parameter int MAX_REACT_MS = 9999
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            i_start,
   input  logic            i_react,
   input  logic [MS_W-1:0] i_timer_ms,
   output logic            o_timer_en,
   output logic            o_led_go,
   output logic [MS_W-1:0] o_result_ms,
   output logic            o_result_valid,
   output logic            o_false_start,
   output logic            o_timeout
`ifdef REACTION_BEST_SCORE_EN
   ,
   output logic [MS_W-1:0] o_best_ms
`endif
);

   localparam int PW = (CLKS_PER_MS > 1) ? $clog2(CLKS_PER_MS) : 1;
   localparam logic [PW-1:0]   PRESC_LAST = PW'(CLKS_PER_MS - 1);
   localparam logic [MS_W-1:0] MAX_MS     = MS_W'(MAX_REACT_MS);

   state_t                state;
   logic                  start_q, react_q, start_p, react_p;
   logic [PW-1:0]         presc;
   logic [15:0]           delay;
   logic [MS_W-1:0]       snap;
   logic [RAND_BITS-1:0]  rnd;
   logic [15:0]           delay_load;
   logic [MS_W-1:0]       elapsed;
   logic                  tick;

   lfsr16 #(
      .SEED  (LFSR_SEED),
      .TAPS  (LFSR_TAPS),
      .OUT_W (RAND_BITS)
   ) u_lfsr (
      .clk (clk),
      .rst (rst),
      .rnd (rnd)
   );

   assign delay_load = 16'(MIN_DELAY_MS) + 16'(rnd);
   // Modular difference: timer wrap between snapshot and response is harmless
   assign elapsed    = i_timer_ms - snap;
   assign tick       = (presc == PRESC_LAST);

   // Edge registers start at 1 so a button held through reset gives no pulse
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         start_q <= 1'b1;
         react_q <= 1'b1;
         start_p <= 1'b0;
         react_p <= 1'b0;
      end else begin
         start_q <= i_start;
         react_q <= i_react;
         start_p <= i_start & ~start_q;
         react_p <= i_react & ~react_q;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state          <= IDLE;
         presc          <= '0;
         delay          <= '0;
         snap           <= '0;
         o_timer_en     <= 1'b0;
         o_led_go       <= 1'b0;
         o_result_ms    <= '0;
         o_result_valid <= 1'b0;
         o_false_start  <= 1'b0;
         o_timeout      <= 1'b0;
`ifdef REACTION_BEST_SCORE_EN
         o_best_ms      <= '1;
`endif
      end else begin
         case (state)
            IDLE, DONE, FALSE_START: begin
               if (start_p) begin
                  state          <= WAIT_RAND;
                  delay          <= delay_load;
                  presc          <= '0;
                  o_result_valid <= 1'b0;
                  o_false_start  <= 1'b0;
                  o_timeout      <= 1'b0;
               end
            end
            WAIT_RAND: begin
               presc <= tick ? '0 : presc + 1'b1;
               if (react_p) begin
                  state         <= FALSE_START;
                  o_false_start <= 1'b1;
                  o_result_ms   <= '0;
               end else if (tick) begin
                  if (delay == 16'd0) begin
                     state      <= GO;
                     snap       <= i_timer_ms;
                     o_led_go   <= 1'b1;
                     o_timer_en <= 1'b1;
                  end else begin
                     delay <= delay - 16'd1;
                  end
               end
            end
            GO: begin
               if (react_p) begin
                  state          <= DONE;
                  o_led_go       <= 1'b0;
                  o_timer_en     <= 1'b0;
                  o_result_ms    <= elapsed;
                  o_result_valid <= 1'b1;
`ifdef REACTION_BEST_SCORE_EN
                  if (elapsed < o_best_ms) o_best_ms <= elapsed;
`endif
               end else if (elapsed >= MAX_MS) begin
                  state       <= DONE;
                  o_led_go    <= 1'b0;
                  o_timer_en  <= 1'b0;
                  o_result_ms <= MAX_MS;
                  o_timeout   <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
